// File: rtl/shift_add_mult_if.sv
// Request/result bundle for the sequential shift-add multiplier.
// The master drives operands and controls; the slave returns status and the product.
interface shift_add_mult_if #(
  parameter int WIDTH = 16
);
  logic               start;
  logic               signed_mode;
  logic               acc_en;
  logic               acc_clr;
  logic [WIDTH-1:0]   multiplicand;
  logic [WIDTH-1:0]   multiplier;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] product;

  modport master (
    output start, signed_mode, acc_en, acc_clr, multiplicand, multiplier,
    input  busy, done, product
  );

  modport slave (
    input  start, signed_mode, acc_en, acc_clr, multiplicand, multiplier,
    output busy, done, product
  );
endinterface

// File: rtl/shift_add_mult.sv
// Radix-2 shift-add multiplier: magnitude multiply over WIDTH cycles, then one
// fix-up cycle that applies the sign and either overwrites or accumulates.
module shift_add_mult #(
  parameter int WIDTH = 16
) (
  input  logic            Clk,
  input  logic            rst_n,
  shift_add_mult_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next;

  logic [WIDTH-1:0]   r_a_mag;
  logic               r_sign;
  logic               r_acc;
  logic [2*WIDTH:0]   r_work;
  logic [CW-1:0]      r_count;
  logic [2*WIDTH-1:0] r_product;
  logic               r_done;

  logic               w_load;
  logic               w_step;
  logic               w_fix;
  logic               w_clr;

  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic               w_sign;
  logic [WIDTH-1:0]   w_addend;
  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH:0]   w_work_step;
  logic [2*WIDTH-1:0] w_raw;
  logic [2*WIDTH-1:0] w_raw_s;
  logic [2*WIDTH-1:0] w_fix_val;

  // Magnitudes fit in WIDTH unsigned bits, including -2^(WIDTH-1).
  assign w_a_mag = (bus.signed_mode && bus.multiplicand[WIDTH-1]) ? -bus.multiplicand
                                                                   : bus.multiplicand;
  assign w_b_mag = (bus.signed_mode && bus.multiplier[WIDTH-1])   ? -bus.multiplier
                                                                   : bus.multiplier;
  assign w_sign  = bus.signed_mode & (bus.multiplicand[WIDTH-1] ^ bus.multiplier[WIDTH-1]);

  // Upper part is < 2^WIDTH after each shift, so the sum never exceeds WIDTH+1 bits.
  assign w_addend    = r_work[0] ? r_a_mag : '0;
  assign w_sum       = r_work[2*WIDTH:WIDTH] + {1'b0, w_addend};
  assign w_work_step = {1'b0, w_sum, r_work[WIDTH-1:1]};

  assign w_raw     = r_work[2*WIDTH-1:0];
  assign w_raw_s   = r_sign ? -w_raw : w_raw;
  assign w_fix_val = r_acc ? (r_product + w_raw_s) : w_raw_s;

  always_ff @(posedge Clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    w_step = 1'b0;
    w_fix  = 1'b0;
    w_clr  = 1'b0;
    case (r_state)
      IDLE: begin
        w_clr = bus.acc_clr;
        if (bus.start) begin
          w_load = 1'b1;
          w_next = CALC;
        end
      end
      CALC: begin
        w_step = 1'b1;
        if (r_count == CW'(1)) w_next = FIX;
      end
      FIX: begin
        w_fix  = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_mag   <= '0;
      r_sign    <= 1'b0;
      r_acc     <= 1'b0;
      r_work    <= '0;
      r_count   <= '0;
      r_product <= '0;
      r_done    <= 1'b0;
    end else begin
      r_done <= w_fix;
      if (w_load) begin
        r_a_mag <= w_a_mag;
        r_sign  <= w_sign;
        r_acc   <= bus.acc_en;
        r_work  <= {{(WIDTH+1){1'b0}}, w_b_mag};
        r_count <= CW'(WIDTH);
      end else if (w_step) begin
        r_work  <= w_work_step;
        r_count <= r_count - CW'(1);
      end
      // A clear issued with start lands before FIX, so accumulation starts from zero.
      if (w_fix)      r_product <= w_fix_val;
      else if (w_clr) r_product <= '0;
    end
  end

  assign bus.busy    = (r_state != IDLE);
  assign bus.done    = r_done;
  assign bus.product = r_product;

endmodule

// File: tb/tb_shift_add_mult.sv
// Randomized bench for shift_add_mult with a plain-arithmetic product model.
module tb_shift_add_mult;
  localparam int W = 16;
  localparam logic [63:0] MASK = (64'd1 << (2*W)) - 64'd1;

  logic Clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  logic [63:0] exp_prod;

  shift_add_mult_if #(.WIDTH(W)) bus();
  shift_add_mult #(.WIDTH(W)) dut (.Clk(Clk), .rst_n(rst_n), .bus(bus));

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  function automatic void model_op(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input bit sm, input bit acc, input bit clr);
    longint sa, sb;
    logic [63:0] p;
    sa = sm ? longint'($signed(a)) : longint'(a);
    sb = sm ? longint'($signed(b)) : longint'(b);
    p  = 64'(sa * sb) & MASK;
    if (clr) exp_prod = '0;
    exp_prod = acc ? ((exp_prod + p) & MASK) : p;
  endfunction

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit sm,
                       input bit acc, input bit clr,
                       output int lat, output int bcyc, output bit dn_after);
    @(negedge Clk);
    bus.multiplicand = a; bus.multiplier = b; bus.signed_mode = sm;
    bus.acc_en = acc; bus.acc_clr = clr; bus.start = 1'b1;
    @(posedge Clk); #1;
    bus.start = 1'b0; bus.acc_clr = 1'b0;
    bus.multiplicand = W'($urandom); bus.multiplier = W'($urandom);
    bus.signed_mode = ~sm; bus.acc_en = ~acc;
    lat = -1; bcyc = 0;
    for (int i = 0; i < 4*W; i++) begin
      @(negedge Clk);
      if (bus.busy) bcyc++;
      if (bus.done) begin lat = i; break; end
    end
    @(negedge Clk);
    dn_after = bus.done;
    model_op(a, b, sm, acc, clr);
  endtask

  task automatic test_reset;
    int lat;
    rst_n = 1'b0;
    bus.start = 1'b1; bus.signed_mode = 1'b0; bus.acc_en = 1'b0; bus.acc_clr = 1'b0;
    bus.multiplicand = 16'd3; bus.multiplier = 16'd5;
    #3;
    n_checks++;
    if ({bus.busy, bus.done, bus.product} !== {2'b00, 32'h0}) begin
      n_fail++;
      $display("FAIL reset_state: busy=%0b done=%0b product=%h, want 0/0/0", bus.busy, bus.done, bus.product);
    end
    repeat (2) @(negedge Clk);
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hold: busy=%0b while rst_n low, want 0", bus.busy);
    end
    rst_n = 1'b1;
    @(posedge Clk); #1;
    n_checks++;
    if (bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL first_start_after_reset: busy=%0b, want 1", bus.busy);
    end
    bus.start = 1'b0;
    lat = -1;
    for (int i = 0; i < 4*W; i++) begin
      @(negedge Clk);
      if (bus.done) begin lat = i; break; end
    end
    model_op(16'd3, 16'd5, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (lat != W+1 || bus.product !== exp_prod[31:0]) begin
      n_fail++;
      $display("FAIL reset_first_op: lat=%0d product=%h, want %0d/%h", lat, bus.product, W+1, exp_prod[31:0]);
    end
  endtask

  task automatic test_basic;
    int lat, bcyc; bit dn;
    do_op(16'd3, 16'd5, 1'b0, 1'b0, 1'b0, lat, bcyc, dn);
    n_checks++;
    if (bus.product !== 32'h0000000F) begin
      n_fail++; $display("FAIL basic_product: got %h want 0000000f", bus.product);
    end
    n_checks++;
    if (lat != 17) begin
      n_fail++; $display("FAIL basic_latency: got %0d want 17", lat);
    end
    n_checks++;
    if (bcyc != 17) begin
      n_fail++; $display("FAIL basic_busy_cycles: got %0d want 17", bcyc);
    end
    n_checks++;
    if (dn !== 1'b0) begin
      n_fail++; $display("FAIL basic_done_width: done still %0b one cycle later, want 0", dn);
    end
  endtask

  task automatic test_signed;
    int lat, bcyc; bit dn;
    do_op(16'hFFF9, 16'd6, 1'b1, 1'b0, 1'b0, lat, bcyc, dn);
    n_checks++;
    if (bus.product !== 32'hFFFFFFD6) begin
      n_fail++; $display("FAIL signed_neg: got %h want ffffffd6", bus.product);
    end
    do_op(16'h8000, 16'h8000, 1'b1, 1'b0, 1'b0, lat, bcyc, dn);
    n_checks++;
    if (bus.product !== 32'h40000000 || lat != 17) begin
      n_fail++; $display("FAIL signed_minmin: got %h lat %0d want 40000000 lat 17", bus.product, lat);
    end
  endtask

  task automatic test_accum;
    int lat, bcyc; bit dn;
    do_op(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b0, lat, bcyc, dn);
    n_checks++;
    if (bus.product !== 32'hFFFE0001) begin
      n_fail++; $display("FAIL accum_max: got %h want fffe0001", bus.product);
    end
    do_op(16'd2, 16'd1, 1'b0, 1'b1, 1'b0, lat, bcyc, dn);
    n_checks++;
    if (bus.product !== 32'hFFFE0003) begin
      n_fail++; $display("FAIL accum_add: got %h want fffe0003", bus.product);
    end
    do_op(16'd4, 16'd4, 1'b0, 1'b1, 1'b1, lat, bcyc, dn);
    n_checks++;
    if (bus.product !== 32'h00000010) begin
      n_fail++; $display("FAIL accum_clr_start: got %h want 00000010", bus.product);
    end
  endtask

  task automatic test_wrap;
    int lat, bcyc; bit dn;
    do_op(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 1'b0, lat, bcyc, dn);
    do_op(16'hFFFF, 16'd2, 1'b0, 1'b1, 1'b0, lat, bcyc, dn);
    n_checks++;
    if (bus.product !== 32'hFFFFFFFF) begin
      n_fail++; $display("FAIL wrap_setup: got %h want ffffffff", bus.product);
    end
    do_op(16'd1, 16'd2, 1'b0, 1'b1, 1'b0, lat, bcyc, dn);
    n_checks++;
    if (bus.product !== 32'h00000001) begin
      n_fail++; $display("FAIL wrap_result: got %h want 00000001", bus.product);
    end
  endtask

  task automatic test_clear;
    @(negedge Clk);
    bus.acc_clr = 1'b1;
    @(negedge Clk);
    bus.acc_clr = 1'b0;
    exp_prod = '0;
    n_checks++;
    if (bus.product !== 32'h0 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL idle_clear: product=%h busy=%0b, want 0/0", bus.product, bus.busy);
    end
  endtask

  task automatic test_zero;
    int lat, bcyc; bit dn;
    do_op(16'd0, W'($urandom), 1'b1, 1'b0, 1'b0, lat, bcyc, dn);
    n_checks++;
    if (bus.product !== exp_prod[31:0] || lat != 17 || bcyc != 17) begin
      n_fail++; $display("FAIL zero_operand: product=%h lat=%0d busy=%0d want %h/17/17",
                         bus.product, lat, bcyc, exp_prod[31:0]);
    end
  endtask

  task automatic test_start_held;
    logic [W-1:0] a0, b0, a1, b1;
    int ndone, first_at, second_at;
    a0 = W'($urandom); b0 = W'($urandom); a1 = W'($urandom); b1 = W'($urandom);
    ndone = 0; first_at = -1; second_at = -1;
    @(negedge Clk);
    bus.multiplicand = a0; bus.multiplier = b0; bus.signed_mode = 1'b0;
    bus.acc_en = 1'b0; bus.acc_clr = 1'b0; bus.start = 1'b1;
    @(posedge Clk);
    for (int i = 0; i < 6*W && ndone < 2; i++) begin
      @(negedge Clk);
      if (bus.done) begin
        ndone++;
        if (ndone == 1) begin
          first_at = i;
          model_op(a0, b0, 1'b0, 1'b0, 1'b0);
          n_checks++;
          if (bus.product !== exp_prod[31:0]) begin
            n_fail++; $display("FAIL held_first: got %h want %h", bus.product, exp_prod[31:0]);
          end
          bus.multiplicand = a1; bus.multiplier = b1; bus.signed_mode = 1'b0;
          bus.acc_en = 1'b0; bus.acc_clr = 1'b0;
        end else begin
          second_at = i;
          model_op(a1, b1, 1'b0, 1'b0, 1'b0);
          n_checks++;
          if (bus.product !== exp_prod[31:0]) begin
            n_fail++; $display("FAIL held_second: got %h want %h", bus.product, exp_prod[31:0]);
          end
          bus.start = 1'b0;
        end
      end else begin
        bus.multiplicand = W'($urandom); bus.multiplier = W'($urandom);
        bus.signed_mode = 1'($urandom); bus.acc_en = 1'($urandom); bus.acc_clr = 1'($urandom);
      end
    end
    bus.start = 1'b0; bus.acc_clr = 1'b0;
    n_checks++;
    if (first_at != W+1 || second_at != 2*W+3) begin
      n_fail++; $display("FAIL held_timing: dones at %0d,%0d want %0d,%0d", first_at, second_at, W+1, 2*W+3);
    end
    @(negedge Clk);
    n_checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL held_no_extra: done=%0b busy=%0b want 0/0", bus.done, bus.busy);
    end
  endtask

  task automatic test_reset_mid;
    int lat, bcyc, ndone; bit dn;
    do_op(16'h1234, 16'h0055, 1'b0, 1'b0, 1'b0, lat, bcyc, dn);
    @(negedge Clk);
    bus.multiplicand = 16'h00FF; bus.multiplier = 16'h0101; bus.start = 1'b1;
    @(posedge Clk); #1;
    bus.start = 1'b0;
    repeat (8) @(negedge Clk);
    rst_n = 1'b0;
    #1;
    exp_prod = '0;
    n_checks++;
    if (bus.busy !== 1'b0 || bus.product !== 32'h0 || bus.done !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_async: busy=%0b product=%h done=%0b want 0/0/0",
                         bus.busy, bus.product, bus.done);
    end
    @(negedge Clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (W+4) begin
      @(negedge Clk);
      if (bus.done) ndone++;
    end
    n_checks++;
    if (ndone != 0 || bus.product !== 32'h0) begin
      n_fail++; $display("FAIL reset_mid_abort: dones=%0d product=%h want 0/0", ndone, bus.product);
    end
    do_op(16'h0013, 16'h0007, 1'b0, 1'b1, 1'b0, lat, bcyc, dn);
    n_checks++;
    if (bus.product !== exp_prod[31:0] || lat != 17) begin
      n_fail++; $display("FAIL reset_mid_resume: product=%h lat=%0d want %h/17", bus.product, lat, exp_prod[31:0]);
    end
  endtask

  task automatic test_random;
    logic [W-1:0] edges [5];
    logic [W-1:0] a, b;
    int lat, bcyc; bit dn;
    edges = '{16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF};
    for (int n = 0; n < 30; n++) begin
      a = ($urandom_range(3) == 0) ? edges[$urandom_range(4)] : W'($urandom);
      b = ($urandom_range(3) == 0) ? edges[$urandom_range(4)] : W'($urandom);
      do_op(a, b, 1'($urandom), 1'($urandom), ($urandom_range(4) == 0), lat, bcyc, dn);
      n_checks++;
      if (bus.product !== exp_prod[31:0] || lat != W+1 || dn !== 1'b0) begin
        n_fail++; $display("FAIL random_op %0d: a=%h b=%h product=%h lat=%0d want %h lat %0d",
                           n, a, b, bus.product, lat, exp_prod[31:0], W+1);
      end
      repeat ($urandom_range(2)) @(negedge Clk);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    exp_prod = '0;
    test_reset;
    test_basic;
    test_signed;
    test_accum;
    test_wrap;
    test_clear;
    test_zero;
    test_start_held;
    test_reset_mid;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/shift_add_mult.md
SHIFT_ADD_MULT -- requirements
Module: shift_add_mult

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the operand width in bits (legal range 4..32).
REQ-002 The block SHALL have port Clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: request a multiply; sampled only in IDLE.
REQ-005 The block SHALL have port signed_mode, input, 1 bit: 1 = two's-complement operands, 0 = unsigned; sampled with start.
REQ-006 The block SHALL have port acc_en, input, 1 bit: 1 = add the new result to product, 0 = overwrite product; sampled with start.
REQ-007 The block SHALL have port acc_clr, input, 1 bit: synchronous clear of product; honoured only in IDLE.
REQ-008 The block SHALL have port multiplicand, input, WIDTH bits: operand A; sampled with start.
REQ-009 The block SHALL have port multiplier, input, WIDTH bits: operand B; sampled with start.
REQ-010 The block SHALL have port busy, output, 1 bit: high whenever state is not IDLE.
REQ-011 The block SHALL have port done, output, 1 bit: one-cycle pulse when product has been updated.
REQ-012 The block SHALL have port product, output, 2*WIDTH bits: result/accumulator register, held between operations.

Function
REQ-013 The FSM SHALL have states IDLE, CALC and FIX.
REQ-014 In IDLE with start=1, the block SHALL latch |A| and |B| (magnitudes when signed_mode=1, raw otherwise), the result sign (A[msb] XOR B[msb] when signed, else 0) and acc_en, and SHALL clear the working register to {(WIDTH+1)'b0, |B|}, set count=WIDTH and go to CALC.
REQ-015 The working register SHALL be 2*WIDTH+1 bits: upper WIDTH+1 bits partial sum including carry, lower WIDTH bits the multiplier.
REQ-016 Each CALC cycle SHALL do the following as one combined step: if working[0]=1, add |A| into the upper part; shift the whole register right by 1; decrement count.
REQ-017 When count reaches 0, CALC SHALL go to FIX; CALC SHALL last exactly WIDTH cycles.
REQ-018 In FIX, raw = working[2W-1:0], negated when sign=1; product SHALL become product+raw mod 2^(2W) when acc_en=1, otherwise raw; FIX SHALL assert done for that one cycle and return to IDLE.
REQ-019 Latency SHALL be fixed: start sampled at edge 0 gives product valid and done=1 after edge WIDTH+1; busy SHALL be high from edge 0 through edge WIDTH+1.
REQ-020 start while busy SHALL be ignored with no queuing; operands and modes SHALL NOT be resampled mid-operation.
REQ-021 acc_clr in IDLE SHALL zero product at the next edge; acc_clr while busy SHALL be ignored.
REQ-022 acc_clr and start asserted together in IDLE SHALL clear product and start the operation, so that accumulation begins from 0.
REQ-023 In signed mode, the case A=B=-2^(WIDTH-1) SHALL give product 2^(2W-2) exactly, since magnitudes fit in WIDTH unsigned bits.
REQ-024 Accumulation overflow SHALL wrap modulo 2^(2W) silently.
REQ-025 Zero operands SHALL still take the full WIDTH+1-cycle latency, with no early exit.

Reset
REQ-026 rst_n=0 SHALL immediately force state=IDLE, product=0, done=0, busy=0, count=0 and the working register to 0, regardless of Clk.
REQ-027 Reset mid-operation SHALL abort the operation with no done pulse, and product SHALL read 0.
REQ-028 After rst_n deasserts, the first rising edge with start=1 SHALL be accepted.

Verification
REQ-029 Scenario: WIDTH=16, unsigned, A=3, B=5, acc_en=0 -> product=0x0000000F, done pulses exactly 17 cycles after start is sampled, busy high 17 cycles.
REQ-030 Scenario: signed, A=-7 (0xFFF9), B=6 -> product=0xFFFFFFD6; then signed A=B=0x8000 -> product=0x40000000.
REQ-031 Scenario: unsigned 0xFFFF x 0xFFFF, acc_en=0 -> 0xFFFE0001; then 2 x 1 with acc_en=1 -> 0xFFFE0003; then acc_clr+start with 4 x 4 and acc_en=1 -> 0x00000010.
REQ-032 Scenario: product=0xFFFFFFFF via acc, then 1 x 2 with acc_en=1 -> 0x00000001 (wrap).
REQ-033 Scenario: start held high continuously with operands changing during CALC -> only the operands sampled at edge 0 are used, next operation starts the cycle after done, and there is no extra done pulse.
REQ-034 Scenario: rst_n pulsed low at CALC cycle 8 -> busy=0 and product=0 immediately, no done pulse; the next start completes normally.
